// File: rtl/dmem_port_ctrl_if.sv
// Handshake bundle between dmem_port_ctrl, the store buffer, the load unit and the memory port.
// The master modport is the controller side; slave is its environment.
interface dmem_port_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 6
);
    logic              st_retire;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              memoccupy_ld;

    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic [TAG_W-1:0]  ld_tag;
    logic              ld_ready;
    logic              ld_kill;
    logic              sb_hit;
    logic [DATA_W-1:0] sb_data;
    logic              ld_done;
    logic [TAG_W-1:0]  ld_rtag;
    logic [DATA_W-1:0] ld_rdata;
    logic              ld_err;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  st_retire, st_addr, st_data,
        input  ld_req, ld_addr, ld_tag, ld_kill, sb_hit, sb_data,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output memoccupy_ld, ld_ready, ld_done, ld_rtag, ld_rdata, ld_err,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output st_retire, st_addr, st_data,
        output ld_req, ld_addr, ld_tag, ld_kill, sb_hit, sb_data,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  memoccupy_ld, ld_ready, ld_done, ld_rtag, ld_rdata, ld_err,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_port_ctrl.sv
// Single-port data-memory controller behind the store buffer: posted stores, loads with
// store-buffer forwarding, kill support. Define DMEM_TIMEOUT_EN for the load-response watchdog.
module dmem_port_ctrl #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TAG_W   = 6,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    dmem_port_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE,
        FWD,
        LD_REQ,
        LD_WAIT,
        LD_RESP
    } state_e;

    state_e            state_q, state_d;
    logic              st_pend_q, st_pend_d;
    logic [ADDR_W-1:0] st_addr_q, st_addr_d;
    logic [DATA_W-1:0] st_data_q, st_data_d;
    logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              kill_q, kill_d;

    logic ready;
    logic accept;
    logic load_issue;
    logic done_slot;

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    assign ready      = (state_q == IDLE) && !st_pend_q;
    assign accept     = bus.ld_req && ready && !bus.st_retire;
    assign load_issue = (state_q == LD_REQ);
    assign done_slot  = (state_q == FWD) || (state_q == LD_RESP);

    always_comb begin
        state_d   = state_q;
        st_pend_d = st_pend_q;
        st_addr_d = st_addr_q;
        st_data_d = st_data_q;
        ld_addr_d = ld_addr_q;
        rdata_d   = rdata_q;
        tag_d     = tag_q;
        kill_d    = kill_q;
`ifdef DMEM_TIMEOUT_EN
        cnt_d     = '0;
        err_d     = err_q;
`endif

        // A retire that collides with a pending store is dropped so the posted write stays stable.
        if (bus.st_retire && !st_pend_q) begin
            st_pend_d = 1'b1;
            st_addr_d = bus.st_addr;
            st_data_d = bus.st_data;
        end else if (st_pend_q && bus.mem_gnt && !load_issue) begin
            st_pend_d = 1'b0;
        end

        if ((state_q != IDLE) && bus.ld_kill) begin
            kill_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    tag_d  = bus.ld_tag;
                    kill_d = bus.ld_kill;
                    if (bus.sb_hit) begin
                        state_d = FWD;
                        rdata_d = bus.sb_data;
                    end else begin
                        state_d   = LD_REQ;
                        ld_addr_d = bus.ld_addr;
                    end
                end
            end
            FWD, LD_RESP: begin
                state_d = IDLE;
                kill_d  = 1'b0;
`ifdef DMEM_TIMEOUT_EN
                err_d   = 1'b0;
`endif
            end
            LD_REQ: begin
                if (bus.mem_gnt) begin
                    state_d = LD_WAIT;
                end
            end
            LD_WAIT: begin
                if (bus.mem_rvalid) begin
                    rdata_d = bus.mem_rdata;
                    state_d = LD_RESP;
`ifdef DMEM_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT - 2)) begin
                    // Response slot lands on the TIMEOUT-th cycle after entering LD_WAIT.
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = LD_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            st_pend_q <= 1'b0;
            st_addr_q <= '0;
            st_data_q <= '0;
            ld_addr_q <= '0;
            rdata_q   <= '0;
            tag_q     <= '0;
            kill_q    <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            st_pend_q <= st_pend_d;
            st_addr_q <= st_addr_d;
            st_data_q <= st_data_d;
            ld_addr_q <= ld_addr_d;
            rdata_q   <= rdata_d;
            tag_q     <= tag_d;
            kill_q    <= kill_d;
`ifdef DMEM_TIMEOUT_EN
            cnt_q     <= cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    assign bus.memoccupy_ld = bus.ld_req || (state_q != IDLE) || st_pend_q;
    assign bus.ld_ready     = ready;
    // A kill arriving in the result cycle itself also squashes the result.
    assign bus.ld_done      = done_slot && !kill_q && !bus.ld_kill;
    assign bus.ld_rtag      = tag_q;
    assign bus.ld_rdata     = rdata_q;

`ifdef DMEM_TIMEOUT_EN
    assign bus.ld_err       = bus.ld_done && err_q;
`else
    assign bus.ld_err       = 1'b0;
`endif

    assign bus.mem_req      = load_issue || st_pend_q;
    assign bus.mem_we       = !load_issue;
    assign bus.mem_addr     = load_issue ? ld_addr_q : st_addr_q;
    assign bus.mem_wdata    = st_data_q;

endmodule

// File: tb/tb_dmem_port_ctrl.sv
// Directed, table-driven bench for dmem_port_ctrl with hand-written reset, collision
// and watchdog sequences.
module tb_dmem_port_ctrl;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    dmem_port_ctrl_if #(.ADDR_W(32), .DATA_W(32), .TAG_W(6)) bus ();

    dmem_port_ctrl #(.ADDR_W(32), .DATA_W(32), .TAG_W(6), .TIMEOUT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ctl = {reset, st_retire, ld_req, ld_kill, sb_hit, mem_gnt, mem_rvalid}
    // exp = {memoccupy_ld, ld_ready, ld_done, mem_req, mem_we}
    typedef struct {
        logic [6:0]  ctl;
        logic [31:0] a;
        logic [31:0] d;
        logic [5:0]  tag;
        logic [4:0]  exp;
        logic [31:0] ea;
        logic [31:0] ed;
        logic [5:0]  et;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [6:0] ctl, input logic [31:0] a, input logic [31:0] d,
                                input logic [5:0] tag, input logic [4:0] exp,
                                input logic [31:0] ea, input logic [31:0] ed, input logic [5:0] et);
        vec_t v;
        v.ctl = ctl; v.a = a; v.d = d; v.tag = tag;
        v.exp = exp; v.ea = ea; v.ed = ed; v.et = et;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drv(input logic [6:0] ctl, input logic [31:0] a, input logic [31:0] d,
                       input logic [5:0] tag);
        @(negedge clk);
        {reset, bus.st_retire, bus.ld_req, bus.ld_kill, bus.sb_hit, bus.mem_gnt, bus.mem_rvalid} = ctl;
        bus.st_addr   = a;
        bus.ld_addr   = a;
        bus.st_data   = d;
        bus.sb_data   = d;
        bus.mem_rdata = d;
        bus.ld_tag    = tag;
        #2;
    endtask

    localparam logic [6:0] NOP = 7'b0_0_0_0_0_0_0;
    localparam logic [6:0] RST = 7'b1_0_0_0_0_0_0;
    localparam logic [6:0] SR  = 7'b0_1_0_0_0_0_0;
    localparam logic [6:0] LR  = 7'b0_0_1_0_0_0_0;
    localparam logic [6:0] LRH = 7'b0_0_1_0_1_0_0;
    localparam logic [6:0] LRG = 7'b0_0_1_0_0_1_0;
    localparam logic [6:0] LHK = 7'b0_0_1_1_1_0_0;
    localparam logic [6:0] KL  = 7'b0_0_0_1_0_0_0;
    localparam logic [6:0] GN  = 7'b0_0_0_0_0_1_0;
    localparam logic [6:0] RV  = 7'b0_0_0_0_0_0_1;

    initial begin
        reset = 1'b1;
        {bus.st_retire, bus.ld_req, bus.ld_kill, bus.sb_hit, bus.mem_gnt, bus.mem_rvalid} = '0;
        bus.st_addr = '0; bus.ld_addr = '0; bus.st_data = '0;
        bus.sb_data = '0; bus.mem_rdata = '0; bus.ld_tag = '0;

        // forwarded hit
        tbl.push_back(mk(LRH, 32'h100, 32'hDEADBEEF, 6'd5, 5'b1_1_0_0_0, 0, 0, 0));
        tbl.push_back(mk(NOP, 0, 0, 0, 5'b1_0_1_0_0, 0, 32'hDEADBEEF, 6'd5));
        tbl.push_back(mk(NOP, 0, 0, 0, 5'b0_1_0_0_0, 0, 0, 0));
        // miss with grant two cycles late
        tbl.push_back(mk(LR,  32'h200, 0, 6'd3, 5'b1_1_0_0_0, 0, 0, 0));
        tbl.push_back(mk(NOP, 0, 0, 0, 5'b1_0_0_1_0, 32'h200, 0, 0));
        tbl.push_back(mk(NOP, 0, 0, 0, 5'b1_0_0_1_0, 32'h200, 0, 0));
        tbl.push_back(mk(GN,  0, 0, 0, 5'b1_0_0_1_0, 32'h200, 0, 0));
        tbl.push_back(mk(NOP, 0, 0, 0, 5'b1_0_0_0_0, 0, 0, 0));
        tbl.push_back(mk(RV,  0, 32'h12345678, 0, 5'b1_0_0_0_0, 0, 0, 0));
        tbl.push_back(mk(NOP, 0, 0, 0, 5'b1_0_1_0_0, 0, 32'h12345678, 6'd3));
        tbl.push_back(mk(NOP, 0, 0, 0, 5'b0_1_0_0_0, 0, 0, 0));
        // posted store stalled three cycles, load queued behind it
        tbl.push_back(mk(SR,  32'h40, 32'hA5, 0, 5'b0_1_0_0_0, 0, 0, 0));
        tbl.push_back(mk(NOP, 0, 0, 0, 5'b1_0_0_1_1, 32'h40, 32'hA5, 0));
        tbl.push_back(mk(LR,  32'h300, 0, 6'd7, 5'b1_0_0_1_1, 32'h40, 32'hA5, 0));
        tbl.push_back(mk(LR,  32'h300, 0, 6'd7, 5'b1_0_0_1_1, 32'h40, 32'hA5, 0));
        tbl.push_back(mk(LRG, 32'h300, 0, 6'd7, 5'b1_0_0_1_1, 32'h40, 32'hA5, 0));
        tbl.push_back(mk(LR,  32'h300, 0, 6'd7, 5'b1_1_0_0_0, 0, 0, 0));
        tbl.push_back(mk(GN,  0, 0, 0, 5'b1_0_0_1_0, 32'h300, 0, 0));
        tbl.push_back(mk(RV,  0, 32'h0BADF00D, 0, 5'b1_0_0_0_0, 0, 0, 0));
        tbl.push_back(mk(NOP, 0, 0, 0, 5'b1_0_1_0_0, 0, 32'h0BADF00D, 6'd7));
        tbl.push_back(mk(NOP, 0, 0, 0, 5'b0_1_0_0_0, 0, 0, 0));
        // kill in LD_WAIT, then a normal load
        tbl.push_back(mk(LR,  32'h400, 0, 6'd9, 5'b1_1_0_0_0, 0, 0, 0));
        tbl.push_back(mk(GN,  0, 0, 0, 5'b1_0_0_1_0, 32'h400, 0, 0));
        tbl.push_back(mk(KL,  0, 0, 0, 5'b1_0_0_0_0, 0, 0, 0));
        tbl.push_back(mk(RV,  0, 32'h55, 0, 5'b1_0_0_0_0, 0, 0, 0));
        tbl.push_back(mk(NOP, 0, 0, 0, 5'b1_0_0_0_0, 0, 0, 0));
        tbl.push_back(mk(LRH, 32'h500, 32'h77, 6'd2, 5'b1_1_0_0_0, 0, 0, 0));
        tbl.push_back(mk(NOP, 0, 0, 0, 5'b1_0_1_0_0, 0, 32'h77, 6'd2));
        // kill on the acceptance cycle
        tbl.push_back(mk(LHK, 32'h600, 32'h99, 6'd4, 5'b1_1_0_0_0, 0, 0, 0));
        tbl.push_back(mk(NOP, 0, 0, 0, 5'b1_0_0_0_0, 0, 0, 0));
        tbl.push_back(mk(NOP, 0, 0, 0, 5'b0_1_0_0_0, 0, 0, 0));

        // reset state
        drv(RST, 0, 0, 0);
        drv(RST, 0, 0, 0);
        check("rst occ", bus.memoccupy_ld, 0);
        check("rst ready", bus.ld_ready, 1);
        check("rst done", bus.ld_done, 0);
        check("rst req", bus.mem_req, 0);
        check("rst rtag", bus.ld_rtag, 0);
        check("rst rdata", bus.ld_rdata, 0);
        check("rst err", bus.ld_err, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drv(tbl[i].ctl, tbl[i].a, tbl[i].d, tbl[i].tag);
            check($sformatf("r%0d occ", i), bus.memoccupy_ld, tbl[i].exp[4]);
            check($sformatf("r%0d ready", i), bus.ld_ready, tbl[i].exp[3]);
            check($sformatf("r%0d done", i), bus.ld_done, tbl[i].exp[2]);
            check($sformatf("r%0d req", i), bus.mem_req, tbl[i].exp[1]);
            check($sformatf("r%0d err", i), bus.ld_err, 0);
            if (tbl[i].exp[1]) begin
                check($sformatf("r%0d we", i), bus.mem_we, tbl[i].exp[0]);
                check($sformatf("r%0d addr", i), bus.mem_addr, tbl[i].ea);
                if (tbl[i].exp[0]) check($sformatf("r%0d wdata", i), bus.mem_wdata, tbl[i].ed);
            end
            if (tbl[i].exp[2]) begin
                check($sformatf("r%0d rtag", i), bus.ld_rtag, tbl[i].et);
                check($sformatf("r%0d rdata", i), bus.ld_rdata, tbl[i].ed);
            end
        end

        // reset held two cycles while a miss sits in LD_WAIT
        drv(LR, 32'h700, 0, 6'd1);
        drv(GN, 0, 0, 0);
        drv(NOP, 0, 0, 0);
        check("rw wait req", bus.mem_req, 0);
        drv(7'b1_0_0_0_0_0_1, 0, 32'hCAFE, 0);
        drv(7'b1_0_0_0_0_0_1, 0, 32'hCAFE, 0);
        check("rw rst req", bus.mem_req, 0);
        check("rw rst done", bus.ld_done, 0);
        drv(RV, 0, 32'hCAFE, 0);
        check("rw rel ready", bus.ld_ready, 1);
        check("rw rel occ", bus.memoccupy_ld, 0);
        check("rw rel done", bus.ld_done, 0);
        check("rw rel req", bus.mem_req, 0);
        drv(NOP, 0, 0, 0);
        check("rw late done", bus.ld_done, 0);

        // retire and load in the same cycle: store wins, load not taken
        drv(7'b0_1_1_0_1_0_0, 32'h800, 32'h11, 6'd3);
        check("col ready", bus.ld_ready, 1);
        drv(NOP, 0, 0, 0);
        check("col done", bus.ld_done, 0);
        check("col req", bus.mem_req, 1);
        check("col we", bus.mem_we, 1);
        check("col addr", bus.mem_addr, 32'h800);
        check("col wdata", bus.mem_wdata, 32'h11);
        drv(GN, 0, 0, 0);
        drv(NOP, 0, 0, 0);
        check("col clr req", bus.mem_req, 0);
        check("col clr ready", bus.ld_ready, 1);

`ifdef DMEM_TIMEOUT_EN
        // watchdog: no response for TIMEOUT=8 cycles, then a late rvalid
        drv(LR, 32'h900, 0, 6'd6);
        drv(GN, 0, 0, 0);
        for (int k = 1; k <= 7; k++) begin
            drv(NOP, 0, 0, 0);
            check($sformatf("to w%0d done", k), bus.ld_done, 0);
        end
        drv(NOP, 0, 0, 0);
        check("to done", bus.ld_done, 1);
        check("to err", bus.ld_err, 1);
        check("to rdata", bus.ld_rdata, 0);
        check("to rtag", bus.ld_rtag, 6'd6);
        drv(RV, 0, 32'hABCD, 0);
        check("to late done", bus.ld_done, 0);
        check("to late ready", bus.ld_ready, 1);
        drv(NOP, 0, 0, 0);
        check("to late done2", bus.ld_done, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
